pkmc_sdram_cmd_decoder: RTL

- Snooping decoder for the SDRAM command bus driven by the PKMC SDRAM controller FSM; it is the receiving end of that command encoding.
- Decodes CS/RAS/CAS/WE/BA/A into commands; A10 selects precharge-all vs precharge-one and auto-precharge.
- Tracks per-bank open/closed state and open row, plus the power-up init sequence.
- Flags protocol and timing violations as sticky bits; used as on-chip bus monitor in the board build and as checker in the dafk testbench.

---
 rtl/pkmc_sdram_cmd_decoder_pkg.sv | 53 +++++
 rtl/pkmc_sdram_bank_tracker.sv | 86 ++++++++
 rtl/pkmc_sdram_cmd_decoder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pkmc_sdram_cmd_decoder_pkg.sv
// Shared SDRAM command codes, error bit indices, init states and A10 meanings
// for the PKMC SDRAM command decoder.
package pkmc_sdram_cmd_decoder_pkg;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_ACT   = 3'd1,
    CMD_READ  = 3'd2,
    CMD_WRITE = 3'd3,
    CMD_PRE   = 3'd4,
    CMD_REF   = 3'd5,
    CMD_MRS   = 3'd6,
    CMD_BST   = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    WAIT_PALL = 2'd0,
    REFS      = 2'd1,
    WAIT_MRS  = 2'd2,
    READY     = 2'd3
  } init_state_e;

  localparam int ERR_W         = 5;
  localparam int ERR_ACT_OPEN  = 0;
  localparam int ERR_RW_CLOSED = 1;
  localparam int ERR_REF_OPEN  = 2;
  localparam int ERR_INIT      = 3;
  localparam int ERR_TIMING    = 4;

  localparam int   A10_BIT = 10;
  localparam logic PCH_ALL = 1'b1;
  localparam logic PCH_ONE = 1'b0;

  function automatic cmd_e decode_cmd(input logic cs_n, input logic ras_n,
                                      input logic cas_n, input logic we_n);
    cmd_e c;
    c = CMD_NOP;
    if (!cs_n) begin
      case ({ras_n, cas_n, we_n})
        3'b111:  c = CMD_NOP;
        3'b011:  c = CMD_ACT;
        3'b101:  c = CMD_READ;
        3'b100:  c = CMD_WRITE;
        3'b010:  c = CMD_PRE;
        3'b001:  c = CMD_REF;
        3'b000:  c = CMD_MRS;
        default: c = CMD_BST;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/pkmc_sdram_bank_tracker.sv
// One SDRAM bank: open flag, open row and (with PKMC_SDRAM_TIMING_CHECK_EN)
// tRCD/tRP/tRAS down-counters that flag commands issued too early.
module pkmc_sdram_bank_tracker #(
  parameter int ROW_W = 13
`ifdef PKMC_SDRAM_TIMING_CHECK_EN
  ,
  parameter int T_RCD = 2,
  parameter int T_RP  = 2,
  parameter int T_RAS = 5
`endif
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             act_i,
  input  logic             pre_i,
  input  logic             rw_i,
  input  logic             ap_i,
  input  logic [ROW_W-1:0] row_i,
  output logic             open_o,
  output logic [ROW_W-1:0] row_o
`ifdef PKMC_SDRAM_TIMING_CHECK_EN
  ,
  output logic             timing_err_o
`endif
);

  logic             open_q, open_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             close;

  // Auto-precharge closes the bank just like an explicit precharge.
  assign close  = pre_i || (rw_i && ap_i);
  assign open_d = act_i ? 1'b1 : (close ? 1'b0 : open_q);
  assign row_d  = act_i ? row_i : row_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      open_q <= 1'b0;
      row_q  <= '0;
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
    end
  end

  assign open_o = open_q;
  assign row_o  = row_q;

`ifdef PKMC_SDRAM_TIMING_CHECK_EN
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] RCD_LD = (T_RCD > 1) ? CNT_W'(T_RCD - 1) : '0;
  localparam logic [CNT_W-1:0] RP_LD  = (T_RP  > 1) ? CNT_W'(T_RP  - 1) : '0;
  localparam logic [CNT_W-1:0] RAS_LD = (T_RAS > 1) ? CNT_W'(T_RAS - 1) : '0;

  logic [CNT_W-1:0] trcd_q, trcd_d, trp_q, trp_d, tras_q, tras_d;

  always_comb begin
    trcd_d = (trcd_q != '0) ? trcd_q - CNT_W'(1) : trcd_q;
    trp_d  = (trp_q  != '0) ? trp_q  - CNT_W'(1) : trp_q;
    tras_d = (tras_q != '0) ? tras_q - CNT_W'(1) : tras_q;
    if (act_i) begin
      trcd_d = RCD_LD;
      tras_d = RAS_LD;
    end
    if (close) trp_d = RP_LD;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trcd_q <= '0;
      trp_q  <= '0;
      tras_q <= '0;
    end else begin
      trcd_q <= trcd_d;
      trp_q  <= trp_d;
      tras_q <= tras_d;
    end
  end

  // tRAS only matters when a precharge actually closes an open row.
  assign timing_err_o = (act_i && trp_q != '0) ||
                        (rw_i && trcd_q != '0) ||
                        (pre_i && open_q && tras_q != '0);
`endif

endmodule

// File: rtl/pkmc_sdram_cmd_decoder.sv
// Snooping SDRAM command decoder with per-bank tracking, init FSM and sticky
// protocol error flags. PKMC_SDRAM_TIMING_CHECK_EN adds timing checks (err_o[4]).
module pkmc_sdram_cmd_decoder
  import pkmc_sdram_cmd_decoder_pkg::*;
#(
  parameter int ROW_W     = 13,
  parameter int T_RCD     = 2,
  parameter int T_RP      = 2,
  parameter int T_RAS     = 5,
  parameter int T_RFC     = 7,
  parameter int INIT_REFS = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cs_n_i,
  input  logic               ras_n_i,
  input  logic               cas_n_i,
  input  logic               we_n_i,
  input  logic [1:0]         ba_i,
  input  logic [ROW_W-1:0]   a_i,
  input  logic               err_clr_i,
  output logic [2:0]         cmd_o,
  output logic               cmd_valid_o,
  output logic [3:0]         bank_open_o,
  output logic [4*ROW_W-1:0] open_row_o,
  output logic               init_done_o,
  output logic [ERR_W-1:0]   err_o
);

  cmd_e        cmd, cmd_q;
  logic        cmd_valid_q;
  logic        a10;
  logic [3:0]  bank_sel, act_v, pre_v, rw_v, bank_open;
  logic        timing_err;

  assign cmd      = decode_cmd(cs_n_i, ras_n_i, cas_n_i, we_n_i);
  assign a10      = a_i[A10_BIT];
  assign bank_sel = 4'b0001 << ba_i;
  assign act_v    = (cmd == CMD_ACT) ? bank_sel : 4'b0000;
  assign pre_v    = (cmd != CMD_PRE) ? 4'b0000 : ((a10 == PCH_ONE) ? bank_sel : 4'b1111);
  assign rw_v     = (cmd == CMD_READ || cmd == CMD_WRITE) ? bank_sel : 4'b0000;

`ifdef PKMC_SDRAM_TIMING_CHECK_EN
  logic [3:0] timing_v;
`endif

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
      pkmc_sdram_bank_tracker #(
        .ROW_W(ROW_W)
`ifdef PKMC_SDRAM_TIMING_CHECK_EN
        ,
        .T_RCD(T_RCD),
        .T_RP (T_RP),
        .T_RAS(T_RAS)
`endif
      ) u_bank (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .act_i       (act_v[gi]),
        .pre_i       (pre_v[gi]),
        .rw_i        (rw_v[gi]),
        .ap_i        (a10),
        .row_i       (a_i),
        .open_o      (bank_open[gi]),
        .row_o       (open_row_o[gi*ROW_W +: ROW_W])
`ifdef PKMC_SDRAM_TIMING_CHECK_EN
        ,
        .timing_err_o(timing_v[gi])
`endif
      );
    end
  endgenerate

`ifdef PKMC_SDRAM_TIMING_CHECK_EN
  localparam logic [7:0] RFC_LD = (T_RFC > 1) ? 8'(T_RFC - 1) : 8'd0;
  logic [7:0] trfc_q, trfc_d;

  always_comb begin
    trfc_d = (trfc_q != 8'd0) ? trfc_q - 8'd1 : trfc_q;
    if (cmd == CMD_REF) trfc_d = RFC_LD;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) trfc_q <= 8'd0;
    else         trfc_q <= trfc_d;
  end

  assign timing_err = (|timing_v) || (trfc_q != 8'd0 && cmd != CMD_NOP);
`else
  logic unused_timing;
  assign unused_timing = |{T_RCD, T_RP, T_RAS, T_RFC};
  assign timing_err    = 1'b0;
`endif

  init_state_e       state_q, state_d;
  logic [7:0]        ref_cnt_q, ref_cnt_d;
  logic              init_err, refs_done;
  logic [ERR_W-1:0]  err_q, err_d, err_new;

  assign refs_done = (32'(ref_cnt_q) + 32'd1) >= 32'(INIT_REFS);

  always_comb begin
    state_d   = state_q;
    ref_cnt_d = ref_cnt_q;
    init_err  = 1'b0;
    case (state_q)
      WAIT_PALL: begin
        if (cmd == CMD_PRE) begin
          if (a10 == PCH_ALL) begin
            state_d   = (INIT_REFS == 0) ? WAIT_MRS : REFS;
            ref_cnt_d = '0;
          end
        end else if (cmd != CMD_NOP) begin
          init_err = 1'b1;
        end
      end
      REFS: begin
        if (cmd == CMD_REF) begin
          if (refs_done) begin
            state_d   = WAIT_MRS;
            ref_cnt_d = '0;
          end else begin
            ref_cnt_d = ref_cnt_q + 8'd1;
          end
        end else if (cmd != CMD_NOP && cmd != CMD_PRE) begin
          init_err = 1'b1;
        end
      end
      WAIT_MRS: begin
        if (cmd == CMD_MRS) state_d = READY;
        else if (!(cmd inside {CMD_NOP, CMD_REF, CMD_PRE})) init_err = 1'b1;
      end
      READY: begin
        if (cmd == CMD_MRS && (|bank_open)) init_err = 1'b1;
      end
      default: state_d = WAIT_PALL;
    endcase
  end

  always_comb begin
    err_new                = '0;
    err_new[ERR_ACT_OPEN]  = (cmd == CMD_ACT) && (|(bank_sel & bank_open));
    err_new[ERR_RW_CLOSED] = (cmd == CMD_READ || cmd == CMD_WRITE) && !(|(bank_sel & bank_open));
    err_new[ERR_REF_OPEN]  = (cmd == CMD_REF) && (|bank_open);
    err_new[ERR_INIT]      = init_err;
    err_new[ERR_TIMING]    = timing_err;
    // A fresh violation survives a coincident clear.
    err_d = (err_clr_i ? '0 : err_q) | err_new;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= WAIT_PALL;
      ref_cnt_q   <= '0;
      err_q       <= '0;
      cmd_q       <= CMD_NOP;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_cnt_q   <= ref_cnt_d;
      err_q       <= err_d;
      cmd_q       <= cmd;
      cmd_valid_q <= (cmd != CMD_NOP);
    end
  end

  assign cmd_o       = cmd_q;
  assign cmd_valid_o = cmd_valid_q;
  assign bank_open_o = bank_open;
  assign init_done_o = (state_q == READY);
  assign err_o       = err_q;

endmodule
